// File: rtl/key_uart_tx.sv
// Keypad-to-UART transmitter: press edge detect, ASCII map, code FIFO, 8N1 serialiser.
// Optional KEY_UART_TX_CRLF_EN appends CR and LF frames after every key character.
module key_uart_tx #(
    parameter int CLK_DIV    = 5208,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] num,
    input  logic       signal,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    // state | meaning
    // IDLE  | line high; pops the FIFO head when one is queued
    // START | start bit (low) for CLK_DIV cycles
    // DATA  | data bits, LSB first, CLK_DIV cycles each
    // STOP  | stop bit (high) for CLK_DIV cycles
    // GAP   | one high cycle before a CR/LF frame (CRLF build only)
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef KEY_UART_TX_CRLF_EN
        , GAP
`endif
    } state_t;

    localparam int CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW   = AW + 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [NW-1:0] FIFO_FULL = NW'(FIFO_DEPTH);

    function automatic logic [7:0] to_ascii(input logic [3:0] k);
        if (k <= 4'd9)
            return 8'h30 + {4'h0, k};
        else if (k <= 4'd13)
            return 8'h37 + {4'h0, k};
        else
            return 8'h3F;
    endfunction

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n, idx_inc;
    logic [7:0]    shift, shift_n;
    logic          tx_n, busy_n;
    logic          signal_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count, count_n;
    logic          press, pop, push, full, empty, baud_done;
`ifdef KEY_UART_TX_CRLF_EN
    logic [1:0]    extra, extra_n;
`endif

    assign press     = signal & ~signal_d;
    assign empty     = (count == '0);
    assign full      = (count == FIFO_FULL);
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push      = press & (~full | pop);
    assign baud_done = (cnt == CNT_LAST);
    assign idx_inc   = idx + 3'd1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        tx_n    = tx;
        pop     = 1'b0;
`ifdef KEY_UART_TX_CRLF_EN
        extra_n = extra;
`endif
        case (state)
            IDLE: begin
                tx_n  = 1'b1;
                cnt_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    state_n = DATA;
                    idx_n   = 3'd0;
                    cnt_n   = '0;
                    tx_n    = shift[0];
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    cnt_n = '0;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        idx_n = idx_inc;
                        tx_n  = shift[idx_inc];
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (baud_done) begin
                    cnt_n = '0;
`ifdef KEY_UART_TX_CRLF_EN
                    if (extra != 2'd2) begin
                        state_n = GAP;
                        extra_n = extra + 2'd1;
                    end else begin
                        state_n = IDLE;
                        extra_n = 2'd0;
                    end
`else
                    state_n = IDLE;
`endif
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`ifdef KEY_UART_TX_CRLF_EN
            GAP: begin
                state_n = START;
                cnt_n   = '0;
                tx_n    = 1'b0;
                shift_n = (extra == 2'd1) ? 8'h0D : 8'h0A;
            end
`endif
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
        count_n = count + NW'(push) - NW'(pop);
        busy_n  = (state_n != IDLE) | (count_n != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= 3'd0;
            shift    <= 8'h00;
            tx       <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
            signal_d <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
`ifdef KEY_UART_TX_CRLF_EN
            extra    <= 2'd0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shift    <= shift_n;
            tx       <= tx_n;
            busy     <= busy_n;
            signal_d <= signal;
            count    <= count_n;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (press && full && !pop)
                overflow <= 1'b1;
`ifdef KEY_UART_TX_CRLF_EN
            extra    <= extra_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push)
            mem[wr_ptr] <= to_ascii(num);
    end

endmodule
